// File: rtl/frontend_ftq_if.sv
// Handshake bundle between the fetch target queue and its neighbours.
//   master : the BPU/IFU/backend side (drives enqueue, fetch_ready, commit, flush)
//   slave  : the FTQ itself (drives enq_ready, fetch_*, count, commit_err)
// Signals:
//   flush                     backend flush, squashes every uncommitted entry
//   enq_valid / enq_ready     BPU prediction handshake
//   enq_pc, enq_npc           fetch block PC and predicted next PC
//   enq_slot_valid/_idx       predicted branch slot
//   fetch_valid / fetch_ready IFU handshake
//   fetch_pc, fetch_npc,
//   fetch_slot_valid/_idx     presented entry contents
//   fetch_idx                 FTQ index of the presented entry
//   commit_cnt                entries retired by the backend this cycle
//   count                     occupied entries
//   commit_err                sticky commit-overrun flag
interface frontend_ftq_if #(
    parameter int unsigned PLEN            = 32,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned INSTR_PER_FETCH = 4,
    parameter int unsigned COMMIT_W        = 2
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned SLOT_W = $clog2(INSTR_PER_FETCH);
    localparam int unsigned CNT_W  = $clog2(COMMIT_W + 1);

    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [PLEN-1:0]   enq_pc;
    logic [PLEN-1:0]   enq_npc;
    logic              enq_slot_valid;
    logic [SLOT_W-1:0] enq_slot_idx;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [PLEN-1:0]   fetch_pc;
    logic [PLEN-1:0]   fetch_npc;
    logic              fetch_slot_valid;
    logic [SLOT_W-1:0] fetch_slot_idx;
    logic [IDX_W-1:0]  fetch_idx;
    logic [CNT_W-1:0]  commit_cnt;
    logic [IDX_W:0]    count;
    logic              commit_err;

    modport master (
        output flush, enq_valid, enq_pc, enq_npc, enq_slot_valid, enq_slot_idx,
               fetch_ready, commit_cnt,
        input  enq_ready, fetch_valid, fetch_pc, fetch_npc, fetch_slot_valid,
               fetch_slot_idx, fetch_idx, count, commit_err
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_npc, enq_slot_valid, enq_slot_idx,
               fetch_ready, commit_cnt,
        output enq_ready, fetch_valid, fetch_pc, fetch_npc, fetch_slot_valid,
               fetch_slot_idx, fetch_idx, count, commit_err
    );
endinterface

// File: rtl/frontend_ftq.sv
// Fetch target queue: decouples BPU predictions from IFU/ICache fetch. Entries
// stay allocated until the backend commits them so each in-flight block keeps
// a stable index. Three wrap-bit pointers: head (commit), ifu (fetch), tail
// (enqueue), with head <= ifu <= tail modulo 2^(IDX_W+1).
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    frontend_ftq_if slave modport (enqueue, fetch, commit, flush, status)
module frontend_ftq #(
    parameter int unsigned PLEN            = 32,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned INSTR_PER_FETCH = 4,
    parameter int unsigned COMMIT_W        = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    frontend_ftq_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned SLOT_W = $clog2(INSTR_PER_FETCH);
    localparam int unsigned PTR_W  = IDX_W + 1;

    typedef struct packed {
        logic [PLEN-1:0]   pc;
        logic [PLEN-1:0]   npc;
        logic              slot_valid;
        logic [SLOT_W-1:0] slot_idx;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] ifu_q, ifu_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             err_q, err_d;

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] in_flight;
    logic             full;
    logic             enq_fire;
    logic             fetch_fire;
    logic             overrun;
    entry_t           rd_entry;
    entry_t           wr_entry;

    assign count     = tail_q - head_q;
    assign in_flight = ifu_q - head_q;
    assign full      = (count == PTR_W'(DEPTH));

    // Handshake qualifiers depend only on registered state and flush.
    assign bus.enq_ready   = !full && !bus.flush;
    assign bus.fetch_valid = (ifu_q != tail_q) && !bus.flush;
    assign enq_fire        = bus.enq_valid && bus.enq_ready;
    assign fetch_fire      = bus.fetch_valid && bus.fetch_ready;

    assign rd_entry             = mem_q[ifu_q[IDX_W-1:0]];
    assign bus.fetch_pc         = rd_entry.pc;
    assign bus.fetch_npc        = rd_entry.npc;
    assign bus.fetch_slot_valid = rd_entry.slot_valid;
    assign bus.fetch_slot_idx   = rd_entry.slot_idx;
    assign bus.fetch_idx        = ifu_q[IDX_W-1:0];
    assign bus.count            = count;
    assign bus.commit_err       = err_q;

    assign wr_entry = '{pc:         bus.enq_pc,
                        npc:        bus.enq_npc,
                        slot_valid: bus.enq_slot_valid,
                        slot_idx:   bus.enq_slot_idx};

    // Committing past the fetch pointer (or an out-of-range count) clamps head
    // to ifu and latches the error flag.
    assign overrun = (32'(bus.commit_cnt) > COMMIT_W) ||
                     (32'(bus.commit_cnt) > 32'(in_flight));

    always_comb begin
        head_d = overrun ? ifu_q : head_q + PTR_W'(bus.commit_cnt);
        ifu_d  = ifu_q;
        tail_d = tail_q;
        err_d  = err_q | overrun;
        if (bus.flush) begin
            // Commit is applied first, then every uncommitted entry is dropped.
            ifu_d  = head_d;
            tail_d = head_d;
        end else begin
            if (fetch_fire) ifu_d = ifu_q + PTR_W'(1);
            if (enq_fire)   tail_d = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            ifu_q  <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            ifu_q  <= ifu_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Storage is not reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (enq_fire) mem_q[tail_q[IDX_W-1:0]] <= wr_entry;
    end
endmodule

// File: tb/tb_frontend_ftq.sv
module tb_frontend_ftq;
    localparam int unsigned PLEN     = 32;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned IPF      = 4;
    localparam int unsigned COMMIT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frontend_ftq_if #(.PLEN(PLEN), .DEPTH(DEPTH), .INSTR_PER_FETCH(IPF),
                      .COMMIT_W(COMMIT_W)) bus ();

    frontend_ftq #(.PLEN(PLEN), .DEPTH(DEPTH), .INSTR_PER_FETCH(IPF),
                   .COMMIT_W(COMMIT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        sv;
        logic [1:0]  si;
        int          idx;
    } exp_t;

    // Reference model: pending-fetch scoreboard plus counts.
    exp_t sb[$];
    int   n_fet    = 0;  // fetched but not yet committed
    int   head_abs = 0;  // total entries ever committed since reset
    bit   m_err    = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against model, then advance the model for the edge.
    always @(negedge clk) begin
        int  cnt, tail_idx, c;
        bit  e_ready, e_valid, do_enq, do_fetch;
        exp_t e;
        if (rst) begin
            sb.delete();
            n_fet    = 0;
            head_abs = 0;
            m_err    = 1'b0;
        end
        cnt     = n_fet + sb.size();
        e_ready = (cnt < DEPTH) && !bus.flush;
        e_valid = (sb.size() > 0) && !bus.flush;
        chk("enq_ready", 64'(bus.enq_ready), 64'(e_ready));
        chk("fetch_valid", 64'(bus.fetch_valid), 64'(e_valid));
        chk("count", 64'(bus.count), 64'(cnt));
        chk("commit_err", 64'(bus.commit_err), 64'(m_err));
        if (e_valid) begin
            chk("fetch_pc", 64'(bus.fetch_pc), 64'(sb[0].pc));
            chk("fetch_npc", 64'(bus.fetch_npc), 64'(sb[0].npc));
            chk("fetch_slot_valid", 64'(bus.fetch_slot_valid), 64'(sb[0].sv));
            chk("fetch_slot_idx", 64'(bus.fetch_slot_idx), 64'(sb[0].si));
            chk("fetch_idx", 64'(bus.fetch_idx), 64'(sb[0].idx));
        end
        if (!rst) begin
            tail_idx = (head_abs + cnt) % DEPTH;
            do_enq   = bus.enq_valid && e_ready;
            do_fetch = bus.fetch_ready && e_valid;
            c = int'(bus.commit_cnt);
            if (c > COMMIT_W || c > n_fet) begin
                m_err = 1'b1;
                c     = n_fet;
            end
            head_abs += c;
            n_fet    -= c;
            if (bus.flush) begin
                sb.delete();
                n_fet = 0;
            end else begin
                if (do_fetch) begin
                    void'(sb.pop_front());
                    n_fet++;
                end
                if (do_enq) begin
                    e.pc  = bus.enq_pc;
                    e.npc = bus.enq_npc;
                    e.sv  = bus.enq_slot_valid;
                    e.si  = bus.enq_slot_idx;
                    e.idx = tail_idx;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic drive(input bit ev, input logic [31:0] pc, input bit fr,
                         input logic [1:0] cc, input bit fl);
        bus.enq_valid      = ev;
        bus.enq_pc         = pc;
        bus.enq_npc        = pc ^ 32'h0000_1230;
        bus.enq_slot_valid = pc[4];
        bus.enq_slot_idx   = pc[6:5];
        bus.fetch_ready    = fr;
        bus.commit_cnt     = cc;
        bus.flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bit          ev, fr, fl;
        logic [31:0] pc;
        int          cc, lim;

        bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_npc = '0;
        bus.enq_slot_valid = 1'b0; bus.enq_slot_idx = '0; bus.fetch_ready = 1'b0;
        bus.commit_cnt = '0; bus.flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);

        // Fill to full with IFU stalled; 9th offer must be refused.
        for (int k = 0; k < 9; k++) drive(1'b1, 32'h8000_0000 + 32'(16 * k), 1'b0, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);

        // Latency and ordering from empty.
        do_reset();
        drive(1'b1, 32'h100, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h110, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h120, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 32'h0, 1'b1, 2'd0, 1'b0);

        // Flush with same-cycle commit: build tail=6, ifu=4, head=1.
        do_reset();
        for (int k = 0; k < 6; k++) drive(1'b1, 32'h4000 + 32'(16 * k), 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 32'h0, 1'b1, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 32'hdead_0000, 1'b1, 2'd2, 1'b1);
        drive(1'b1, 32'h5000, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd1, 1'b0);

        // Commit overrun: ifu = head + 1, commit 2; flag stays until reset.
        do_reset();
        drive(1'b1, 32'h200, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h210, 1'b1, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 32'h0, 1'b1, 2'd0, 1'b0);
        do_reset();

        // Randomised traffic: wrap, full with commit, flushes, rare overruns/resets.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            ev  = ($urandom_range(0, 3) != 0);
            fr  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 29) == 0);
            pc  = $urandom;
            lim = (n_fet < COMMIT_W) ? n_fet : COMMIT_W;
            cc  = $urandom_range(0, lim);
            if ($urandom_range(0, 99) == 0) cc = 3;
            drive(ev, pc, fr, 2'(cc), fl);
        end
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/frontend_ftq.md
Name: frontend_ftq

Overview:
- Parametrised fetch target queue that decouples the BPU from the IFU/ICache in the next-generation frontend.
- The BPU enqueues one predicted fetch block per cycle. The IFU dequeues blocks in order for ICache access.
- Entries stay allocated until the backend commits them, so each in-flight block keeps a stable FTQ index for later update and redirect.
- A backend flush squashes every uncommitted entry.

Parameters:
- PLEN, 32, physical address width.
- DEPTH, 8, number of entries; a power of two and at least 2.
- INSTR_PER_FETCH, 4, instruction slots per fetch block.
- COMMIT_W, 2, maximum entries freed per cycle.
- Derived: IDX_W = $clog2(DEPTH); SLOT_W = $clog2(INSTR_PER_FETCH); CNT_W = $clog2(COMMIT_W+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  backend flush; squashes all uncommitted entries.
- enq_valid_i  in  1  BPU has a prediction.
- enq_ready_o  out  1  FTQ can accept an entry.
- enq_pc_i  in  PLEN  fetch block PC.
- enq_npc_i  in  PLEN  predicted next PC.
- enq_slot_valid_i  in  1  prediction hit a branch slot.
- enq_slot_idx_i  in  SLOT_W  predicted branch slot.
- fetch_valid_o  out  1  entry available for the IFU.
- fetch_ready_i  in  1  IFU accepts the entry.
- fetch_pc_o  out  PLEN  entry PC.
- fetch_npc_o  out  PLEN  entry predicted NPC.
- fetch_slot_valid_o  out  1  entry slot-valid.
- fetch_slot_idx_o  out  SLOT_W  entry slot index.
- fetch_idx_o  out  IDX_W  FTQ index of the presented entry.
- commit_cnt_i  in  CNT_W  entries to free this cycle (0..COMMIT_W).
- count_o  out  IDX_W+1  occupied entries.
- commit_err_o  out  1  sticky: a commit overran the fetch pointer.

Behaviour:
- Pointers: three registers of IDX_W+1 bits, with the MSB as wrap bit.
  - head = commit pointer.
  - ifu = fetch pointer.
  - tail = BPU enqueue pointer.
  - Invariant: head <= ifu <= tail, measured modulo 2^(IDX_W+1).
- Reset: asynchronous on rst_i.
  - head = ifu = tail = 0 and commit_err_o = 0.
  - Consequently enq_ready_o = 1, fetch_valid_o = 0, count_o = 0.
  - Entry storage is not reset. Reset mid-operation discards everything immediately.
- Derived signals:
  - count_o = tail - head, with wrap-around arithmetic.
  - full = (count_o == DEPTH); empty-for-fetch = (ifu == tail).
- Enqueue:
  - enq_ready_o = !full && !flush_i.
  - On enq_valid_i && enq_ready_o: write entry[tail[IDX_W-1:0]] and increment tail.
  - enq_ready_o depends only on registered state. A same-cycle commit does not free space for a same-cycle enqueue when full.
- Fetch:
  - fetch_valid_o = (ifu != tail) && !flush_i.
  - fetch_* outputs = entry[ifu[IDX_W-1:0]]; fetch_idx_o = ifu[IDX_W-1:0].
  - On fetch_valid_o && fetch_ready_i: increment ifu.
  - No write-to-read bypass. An entry enqueued in cycle N is first presented in cycle N+1.
  - Once fetch_valid_o is asserted, outputs are stable until the handshake or a flush.
- Commit:
  - head += commit_cnt_i every cycle, including flush cycles.
  - If head + commit_cnt_i would pass ifu: clamp head to ifu and set commit_err_o. It stays set until reset.
  - commit_cnt_i > COMMIT_W is treated the same as an overrun.
- Flush (highest priority):
  - Compute head_next (commit applied first), then set ifu = tail = head_next.
  - Enqueue and fetch are suppressed in the flush cycle.
  - The cycle after a flush: count_o = 0, fetch_valid_o = 0, enq_ready_o = 1.
- Simultaneous events:
  - Enqueue, fetch and commit may all fire in one cycle; each pointer updates independently.
  - When DEPTH == 1 entries are occupied, a fetch and an enqueue in the same cycle are legal.
- Wrap-around: pointers roll from 2^(IDX_W+1)-1 to 0. Full/empty discrimination relies on the wrap bit.

Test Plan:
- Reset then idle: hold rst_i, release → enq_ready_o=1, fetch_valid_o=0, count_o=0, commit_err_o=0.
- Fill: DEPTH=8, enqueue 8 PCs 0x8000_0000+16*k with fetch_ready_i=0 → enq_ready_o=0 after 8th; count_o=8; fetch_pc_o=0x8000_0000, fetch_idx_o=0.
- Latency/order: enqueue PC 0x100 into empty FTQ in cycle N → fetch_valid_o first high in N+1; 3 blocks then dequeue → PCs 0x100, 0x110, 0x120 in order, npc/slot fields preserved.
- Wrap + full/commit: 20 blocks through with commit_cnt_i=2 per cycle while full → no enqueue in cycle commit frees space; indexes wrap 7→0; count_o never exceeds 8.
- Flush with same-cycle commit: tail=6, ifu=4, head=1, flush_i=1, commit_cnt_i=2 → next cycle head=ifu=tail=3, count_o=0, enq/fetch in flush cycle ignored.
- Commit overrun: ifu=head+1, commit_cnt_i=2 → head=ifu, commit_err_o=1 and stays 1 until rst_i.
